mouse_packet_framer: RTL and testbench

MOUSE_PACKET_FRAMER -- requirements
Module: mouse_packet_framer

---
 rtl/mouse_pkg.sv | 26 ++
 rtl/mouse_packet_framer_if.sv | 11 +
 rtl/byte_gap_timer.sv | 18 +
 rtl/mouse_packet_framer.sv | 107 ++++++++++
 tb/tb_mouse_packet_framer.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mouse_pkg.sv
// mouse_pkg: PS/2 mouse command/response bytes, framer state encoding and init-sequence helpers.
package mouse_pkg;
   localparam logic [7:0] CMD_RESET  = 8'hFF;
   localparam logic [7:0] CMD_ENABLE = 8'hF4;
   localparam logic [7:0] RSP_ACK    = 8'hFA;
   localparam logic [7:0] RSP_BAT    = 8'hAA;
   localparam logic [7:0] RSP_ID     = 8'h00;
   typedef enum logic [3:0] {
      SEND_RST, WAIT_ACK, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_EN_ACK, B0, B1, B2, FAIL
   } state_t;
   typedef struct packed {
      logic y_ov;
      logic x_ov;
      logic y_sign;
      logic x_sign;
      logic m;
      logic r;
      logic l;
   } flags_t;
   function automatic logic [7:0] init_expect(state_t s);
      return s == WAIT_BAT ? RSP_BAT : s == WAIT_ID ? RSP_ID : RSP_ACK;
   endfunction
   function automatic state_t init_next(state_t s);
      return s == WAIT_ACK ? WAIT_BAT : s == WAIT_BAT ? WAIT_ID : s == WAIT_ID ? SEND_EN : B0;
   endfunction
endpackage

// File: rtl/mouse_packet_framer_if.sv
// mouse_packet_framer_if: byte link between the framer (master) and the PS/2 byte transceiver (slave).
interface mouse_packet_framer_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       tx_done;
   modport master (input rx_data, rx_valid, rx_err, tx_done, output tx_data, tx_req);
   modport slave  (output rx_data, rx_valid, rx_err, tx_done, input tx_data, tx_req);
endinterface

// File: rtl/byte_gap_timer.sv
// byte_gap_timer: counts idle cycles between received bytes, saturating at GAP_CYCLES.
module byte_gap_timer #(
   parameter int GAP_CYCLES = 200000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(GAP_CYCLES + 1);
   logic [W-1:0] cnt_q;
   assign expired = cnt_q == W'(GAP_CYCLES);
   always_ff @(posedge clk or negedge rst)
      if (!rst) cnt_q <= '0;
      else if (clear) cnt_q <= '0;
      else if (enable && !expired) cnt_q <= cnt_q + 1'b1;
endmodule

// File: rtl/mouse_packet_framer.sv
// mouse_packet_framer: brings a PS/2 mouse into streaming mode, then frames its 3-byte movement packets.
module mouse_packet_framer
   import mouse_pkg::*;
#(
   parameter int GAP_CYCLES     = 200000,
   parameter int INIT_RETRY_MAX = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   mouse_packet_framer_if.master        ps2,
   output logic [7:0]                   o_x,
   output logic [7:0]                   o_y,
   output logic                         o_x_sign,
   output logic                         o_y_sign,
   output logic                         o_x_ov,
   output logic                         o_y_ov,
   output logic                         o_l_click,
   output logic                         o_r_click,
   output logic                         o_m_click,
   output logic                         o_valid,
   output logic                         init_done,
   output logic                         init_fail
);
   localparam int RW = $clog2(INIT_RETRY_MAX + 1);
   state_t        state_q, prev_q;
   logic          sent_q, tx_req_q, valid_q;
   logic [RW-1:0] retry_q;
   logic [7:0]    tx_data_q, x_q, pkt_x_q, pkt_y_q;
   flags_t        b0_q, pkt_f_q;
   logic          byte_ok, drop, expired;
   assign byte_ok = ps2.rx_valid && !ps2.rx_err;
   assign drop    = ps2.rx_err || expired;
   // A state change is seen one cycle late through prev_q; that cycle clears the gap count on entry.
   byte_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
      .clk     (clk),
      .rst     (rst),
      .clear   (ps2.rx_valid || state_q != prev_q),
      .enable  (!(state_q inside {SEND_RST, SEND_EN, B0, FAIL})),
      .expired (expired)
   );
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= SEND_RST;
         prev_q    <= SEND_RST;
         sent_q    <= 1'b0;
         tx_req_q  <= 1'b0;
         tx_data_q <= 8'h00;
         retry_q   <= '0;
         valid_q   <= 1'b0;
         b0_q      <= '0;
         x_q       <= 8'h00;
         pkt_x_q   <= 8'h00;
         pkt_y_q   <= 8'h00;
         pkt_f_q   <= '0;
      end else begin
         prev_q   <= state_q;
         tx_req_q <= 1'b0;
         valid_q  <= 1'b0;
         case (state_q)
            SEND_RST, SEND_EN:
               if (!sent_q) begin
                  tx_req_q  <= 1'b1;
                  tx_data_q <= state_q == SEND_RST ? CMD_RESET : CMD_ENABLE;
                  sent_q    <= 1'b1;
               end else if (ps2.tx_done) begin
                  sent_q  <= 1'b0;
                  state_q <= state_q == SEND_RST ? WAIT_ACK : WAIT_EN_ACK;
               end
            WAIT_ACK, WAIT_BAT, WAIT_ID, WAIT_EN_ACK:
               if (byte_ok && ps2.rx_data == init_expect(state_q)) state_q <= init_next(state_q);
               else if (byte_ok || drop) begin
                  retry_q <= retry_q + 1'b1;
                  state_q <= retry_q == RW'(INIT_RETRY_MAX - 1) ? FAIL : SEND_RST;
               end
            B0:
               if (byte_ok && ps2.rx_data[3]) begin
                  b0_q    <= {ps2.rx_data[7:4], ps2.rx_data[2:0]};
                  state_q <= B1;
               end
            B1:
               if (drop) state_q <= B0;
               else if (byte_ok) begin
                  x_q     <= ps2.rx_data;
                  state_q <= B2;
               end
            B2:
               if (drop) state_q <= B0;
               else if (byte_ok) begin
                  pkt_x_q <= x_q;
                  pkt_y_q <= ps2.rx_data;
                  pkt_f_q <= b0_q;
                  valid_q <= 1'b1;
                  state_q <= B0;
               end
            default: ;
         endcase
      end
   end
   assign ps2.tx_req  = tx_req_q;
   assign ps2.tx_data = tx_data_q;
   assign o_x         = pkt_x_q;
   assign o_y         = pkt_y_q;
   assign o_valid     = valid_q;
   assign {o_y_ov, o_x_ov, o_y_sign, o_x_sign, o_m_click, o_r_click, o_l_click} = pkt_f_q;
   assign init_done   = state_q inside {B0, B1, B2};
   assign init_fail   = state_q == FAIL;
endmodule

// File: tb/tb_mouse_packet_framer.sv
// tb_mouse_packet_framer: scoreboard bench for init handshake, packet framing, resync, timeout and reset.
module tb_mouse_packet_framer;
   localparam int GAP = 40;
   typedef struct {
      logic [7:0] x;
      logic [7:0] y;
      logic [6:0] f;
   } pkt_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [7:0] o_x, o_y;
   logic o_x_sign, o_y_sign, o_x_ov, o_y_ov, o_l_click, o_r_click, o_m_click, o_valid;
   logic init_done, init_fail;
   int errors = 0;
   int checks = 0;
   pkt_t exp_q[$];
   logic [7:0] tx_q[$];
   pkt_t mon_e;
   logic prev_v = 1'b0;
   mouse_packet_framer_if bus ();
   mouse_packet_framer #(.GAP_CYCLES(GAP), .INIT_RETRY_MAX(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .ps2       (bus),
      .o_x       (o_x),
      .o_y       (o_y),
      .o_x_sign  (o_x_sign),
      .o_y_sign  (o_y_sign),
      .o_x_ov    (o_x_ov),
      .o_y_ov    (o_y_ov),
      .o_l_click (o_l_click),
      .o_r_click (o_r_click),
      .o_m_click (o_m_click),
      .o_valid   (o_valid),
      .init_done (init_done),
      .init_fail (init_fail)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst && bus.tx_req) begin
         if (tx_q.size() == 0) chk("tx_unexpected", bus.tx_req, 0);
         else chk("tx_data", bus.tx_data, tx_q.pop_front());
      end
      if (o_valid) begin
         chk("valid_pulse", prev_v, 0);
         if (exp_q.size() == 0) chk("valid_unexpected", o_valid, 0);
         else begin
            mon_e = exp_q.pop_front();
            chk("pkt_x", o_x, mon_e.x);
            chk("pkt_y", o_y, mon_e.y);
            chk("pkt_flags", {o_y_ov, o_x_ov, o_y_sign, o_x_sign, o_m_click, o_r_click, o_l_click}, mon_e.f);
         end
      end
      prev_v <= o_valid;
   end
   task automatic send_byte(input logic [7:0] b, input logic err = 1'b0);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      bus.rx_err   = err;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_err   = 1'b0;
   endtask
   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      pkt_t e;
      send_byte(b0);
      send_byte(b1);
      e.x = b1;
      e.y = b2;
      e.f = {b0[7], b0[6], b0[5], b0[4], b0[2], b0[1], b0[0]};
      exp_q.push_back(e);
      send_byte(b2);
      chk("valid_latency", o_valid, 1);
   endtask
   task automatic wait_tx();
      int n = 0;
      while (!bus.tx_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("tx_seen", bus.tx_req, 1);
   endtask
   task automatic pulse_done();
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
   endtask
   task automatic release_rst();
      @(negedge clk);
      rst = 1'b1;
      tx_q.push_back(8'hFF);
      @(negedge clk);
      chk("first_txreq", bus.tx_req, 1);
   endtask
   task automatic do_init();
      wait_tx();
      pulse_done();
      send_byte(8'hFA);
      send_byte(8'hAA);
      send_byte(8'h00);
      tx_q.push_back(8'hF4);
      wait_tx();
      pulse_done();
      chk("init_done_early", init_done, 0);
      send_byte(8'hFA);
      chk("init_done", init_done, 1);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      logic [7:0] r0, r1, r2;
      bus.rx_data  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.rx_err   = 1'b0;
      bus.tx_done  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_xy", {o_x, o_y}, 16'h0000);
      chk("rst_flags", {o_y_ov, o_x_ov, o_y_sign, o_x_sign, o_m_click, o_r_click, o_l_click}, 0);
      chk("rst_tx", {bus.tx_req, bus.tx_data}, 9'h000);
      chk("rst_status", {o_valid, init_done, init_fail}, 3'b000);
      release_rst();
      do_init();
      send_pkt(8'h19, 8'h05, 8'hFE);
      chk("l_click", o_l_click, 1);
      chk("x_sign", o_x_sign, 1);
      chk("y_sign", o_y_sign, 0);
      chk("x_val", o_x, 8'h05);
      chk("y_val", o_y, 8'hFE);
      @(negedge clk);
      chk("valid_one_cycle", o_valid, 0);
      repeat (3) @(negedge clk);
      chk("hold_x", o_x, 8'h05);
      chk("hold_l", o_l_click, 1);
      send_byte(8'h05);
      send_pkt(8'h08, 8'h10, 8'h20);
      send_byte(8'h08);
      send_byte(8'h10);
      repeat (GAP + 10) @(negedge clk);
      send_pkt(8'h08, 8'h01, 8'h02);
      chk("timeout_x", o_x, 8'h01);
      send_byte(8'h08);
      send_byte(8'h55, 1'b1);
      send_pkt(8'h09, 8'h33, 8'h44);
      send_byte(8'h08, 1'b1);
      send_pkt(8'h0A, 8'h12, 8'h34);
      for (int i = 0; i < 6; i++) begin
         r0 = 8'($urandom) | 8'h08;
         r1 = 8'($urandom);
         r2 = 8'($urandom);
         send_pkt(r0, r1, r2);
      end
      send_pkt(8'hFF, 8'h7F, 8'h80);
      send_byte(8'h08);
      send_byte(8'h11);
      #2 rst = 1'b0;
      #1;
      chk("midrst_xy", {o_x, o_y}, 16'h0000);
      chk("midrst_flags", {o_y_ov, o_x_ov, o_y_sign, o_x_sign, o_m_click, o_r_click, o_l_click}, 0);
      chk("midrst_status", {o_valid, bus.tx_req, init_done}, 3'b000);
      release_rst();
      do_init();
      send_pkt(8'h2B, 8'hC0, 8'h0F);
      @(negedge clk);
      rst = 1'b0;
      release_rst();
      for (int i = 0; i < 3; i++) begin
         wait_tx();
         pulse_done();
         if (i < 2) tx_q.push_back(8'hFF);
         send_byte(8'hFC);
      end
      chk("init_fail", init_fail, 1);
      chk("fail_not_done", init_done, 0);
      repeat (30) @(negedge clk);
      chk("fail_sticky", init_fail, 1);
      chk("pkt_left", exp_q.size(), 0);
      chk("tx_left", tx_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
